serial_frame_tx: RTL

//   Parallel-to-serial transmitter. Accepts a WIDTH-bit word through a valid/ready

---
 rtl/serial_frame_tx_if.sv | 12 +
 rtl/serial_frame_tx.sv | 130 +++++++++++++
 2 files changed

// File: rtl/serial_frame_tx_if.sv
// Word handshake between a producer and the serial frame transmitter.
// The producer drives data/valid and the transmitter drives ready.
interface serial_frame_tx_if #(
   parameter int WIDTH = 8
) ();
   logic [WIDTH-1:0] data_in;
   logic             valid_in;
   logic             ready_out;

   modport master (output data_in, output valid_in, input ready_out);
   modport slave  (input data_in, input valid_in, output ready_out);
endinterface

// File: rtl/serial_frame_tx.sv
// Parallel-to-serial transmitter: start bit (0), WIDTH data bits, stop bit (1),
// each bit held CLKS_PER_BIT clocks on q. All outputs are registered.
module serial_frame_tx #(
   parameter int WIDTH        = 8,
   parameter int CLKS_PER_BIT = 4,
   parameter bit MSB_FIRST    = 1'b0
) (
   input  logic              ck,
   input  logic              reset,
   serial_frame_tx_if.slave  s_if,
   output logic              q,
   output logic              busy,
   output logic              done
);
   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_PRE  = CW'(CLKS_PER_BIT - 2);
   localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   state_t           r_state;
   logic [CW-1:0]    r_cnt;
   logic [IW-1:0]    r_idx;
   logic [WIDTH-1:0] r_shift;
   logic             r_q;
   logic             r_busy;
   logic             r_done;
   logic             r_ready;

   logic [WIDTH-1:0] w_shifted;
   logic             w_head;
   logic             w_head_next;
   logic             w_tick_last;

   // The bit on the wire is always the head of the shift register.
   generate
      if (MSB_FIRST) begin : g_msb
         assign w_shifted   = r_shift << 1;
         assign w_head      = r_shift[WIDTH-1];
         assign w_head_next = w_shifted[WIDTH-1];
      end else begin : g_lsb
         assign w_shifted   = r_shift >> 1;
         assign w_head      = r_shift[0];
         assign w_head_next = w_shifted[0];
      end
   endgenerate

   assign w_tick_last = (r_cnt == CNT_LAST);

   always_ff @(posedge ck or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_shift <= '0;
         r_q     <= 1'b1;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_ready <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_ready <= 1'b1;
               r_done  <= 1'b0;
               if (s_if.valid_in && r_ready) begin
                  r_shift <= s_if.data_in;
                  r_state <= S_START;
                  r_cnt   <= '0;
                  r_q     <= 1'b0;
                  r_busy  <= 1'b1;
                  r_ready <= 1'b0;
               end
            end
            S_START: begin
               if (w_tick_last) begin
                  r_state <= S_DATA;
                  r_cnt   <= '0;
                  r_idx   <= '0;
                  r_q     <= w_head;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_DATA: begin
               if (w_tick_last) begin
                  r_cnt <= '0;
                  if (r_idx == IDX_LAST) begin
                     r_state <= S_STOP;
                     r_idx   <= '0;
                     r_q     <= 1'b1;
                     // A one-clock stop bit is its own final cycle.
                     r_done  <= (CLKS_PER_BIT == 1);
                  end else begin
                     r_idx   <= r_idx + 1'b1;
                     r_shift <= w_shifted;
                     r_q     <= w_head_next;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_STOP: begin
               if (w_tick_last) begin
                  r_state <= S_IDLE;
                  r_cnt   <= '0;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b0;
                  r_ready <= 1'b1;
               end else begin
                  r_cnt  <= r_cnt + 1'b1;
                  r_done <= (r_cnt == CNT_PRE);
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_q     <= 1'b1;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign q              = r_q;
   assign busy           = r_busy;
   assign done           = r_done;
   assign s_if.ready_out = r_ready;
endmodule
